// File: rtl/icap_readback_ctrl.sv
// icap_readback_ctrl: Virtex-6 ICAP configuration readback sequencer.
// Sends the sync/RCFG/FAR/FDRO command words, switches ICAP to read, captures
// the frame words into a small first-word-fall-through FIFO, then desyncs.
// Optional feature macro: RDBK_TIMEOUT_EN (abort READ after TIMEOUT_CYCLES
// consecutive BUSY cycles, flag o_error).
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_start, i_frame_addr,
//   i_word_count                    run request (FAR, FDRO word count)
//   o_busy, o_done, o_error         status
//   o_rd_data, o_rd_valid,
//   i_rd_ready                      readback word stream
//   o_icap_csb, o_icap_rdwrb,
//   o_icap_i, i_icap_o, i_icap_busy ICAP_VIRTEX6 pins (X32)
module icap_readback_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_frame_addr,
  input  logic [26:0] i_word_count,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic        o_icap_csb,
  output logic        o_icap_rdwrb,
  output logic [31:0] o_icap_i,
  input  logic [31:0] i_icap_o,
  input  logic        i_icap_busy
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
  begin : g_param_check
    $error("icap_readback_ctrl: FIFO_DEPTH must be a power of 2 >= 4, TIMEOUT_CYCLES > 0");
  end

  // ICAP expects each byte bit-reversed; the same swap undoes it on readback.
  function automatic logic [31:0] bitrev_bytes(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

  typedef enum logic [2:0] {StIdle, StCmd, StToRd, StRead, StToWr, StDesync} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] far_q, far_d;
  logic [26:0] cnt_q, cnt_d;   // FDRO count during CMD, words remaining during READ
  logic        req_q;          // CSB was low last cycle
  logic        done_q;
  logic        csb, rdwrb, capture;
  logic [31:0] icap_word, cmd_word, desync_word;

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, fifo_cnt;
  logic        empty, full, pop;

  assign fifo_cnt = wr_ptr_q - rd_ptr_q;
  assign empty    = (fifo_cnt == '0);
  assign full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign pop      = !empty && i_rd_ready;

`ifdef RDBK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout;
  logic          error_q;
`endif

  always_comb begin
    cmd_word = 32'h2000_0000;
    case (idx_q)
      4'd0:    cmd_word = 32'hFFFF_FFFF;
      4'd1:    cmd_word = 32'hAA99_5566;
      4'd4:    cmd_word = 32'h3000_8001;
      4'd5:    cmd_word = 32'h0000_0004;
      4'd6:    cmd_word = 32'h3000_2001;
      4'd7:    cmd_word = far_q;
      4'd8:    cmd_word = 32'h2800_6000;
      4'd9:    cmd_word = 32'h4800_0000 | {5'b0, cnt_q};
      default: cmd_word = 32'h2000_0000;
    endcase
    desync_word = 32'h2000_0000;
    case (idx_q)
      4'd0:    desync_word = 32'h3000_8001;
      4'd1:    desync_word = 32'h0000_000D;
      default: desync_word = 32'h2000_0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    far_d     = far_q;
    cnt_d     = cnt_q;
    csb       = 1'b1;
    rdwrb     = 1'b0;
    icap_word = 32'h0;
    capture   = 1'b0;
`ifdef RDBK_TIMEOUT_EN
    to_cnt_d  = '0;
    timeout   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StCmd;
          idx_d   = 4'd0;
          far_d   = i_frame_addr;
          cnt_d   = (i_word_count == '0) ? 27'd1 : i_word_count;
        end
      end
      StCmd: begin
        csb       = 1'b0;
        icap_word = cmd_word;
        idx_d     = idx_q + 4'd1;
        if (idx_q == 4'd11) begin
          state_d = StToRd;
          idx_d   = 4'd0;
        end
      end
      StToRd: begin
        rdwrb   = 1'b1;
        state_d = StRead;
      end
      StRead: begin
        rdwrb   = 1'b1;
        // Keep one free slot for the word requested last cycle.
        csb     = (fifo_cnt > (AW+1)'(FIFO_DEPTH - 2));
        capture = req_q && !i_icap_busy;
        if (capture) begin
          cnt_d = cnt_q - 27'd1;
          if (cnt_q == 27'd1) begin
            csb     = 1'b1;
            state_d = StToWr;
          end
        end
`ifdef RDBK_TIMEOUT_EN
        if (!capture && i_icap_busy && !csb) begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
            state_d = StToWr;
          end
        end
`endif
      end
      StToWr: begin
        state_d = StDesync;
        idx_d   = 4'd0;
      end
      StDesync: begin
        csb       = 1'b0;
        icap_word = desync_word;
        idx_d     = idx_q + 4'd1;
        if (idx_q == 4'd3) begin
          state_d = StIdle;
          idx_d   = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      far_q    <= 32'h0;
      cnt_q    <= 27'd0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      far_q   <= far_d;
      cnt_q   <= cnt_d;
      req_q   <= !csb;
      done_q  <= (state_q == StDesync) && (state_d == StIdle);
      if (capture) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (capture) mem_q[wr_ptr_q[AW-1:0]] <= bitrev_bytes(i_icap_o);
  end

`ifdef RDBK_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (state_q == StIdle && i_start) error_q <= 1'b0;
      else if (timeout)                 error_q <= 1'b1;
    end
  end
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(capture && full));

  assign o_busy       = (state_q != StIdle);
  assign o_done       = done_q;
  assign o_rd_valid   = !empty;
  assign o_rd_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign o_icap_csb   = csb;
  assign o_icap_rdwrb = rdwrb;
  assign o_icap_i     = bitrev_bytes(icap_word);
endmodule

// File: tb/tb_icap_readback_ctrl.sv
// Self-checking bench for icap_readback_ctrl with a behavioural ICAP model.
module tb_icap_readback_ctrl;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 16;
`ifdef RDBK_TIMEOUT_EN
  localparam int StuckLen = 100000;
`else
  localparam int StuckLen = 40;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_frame_addr = '0;
  logic [26:0] i_word_count = '0;
  logic        o_busy, o_done, o_error, o_rd_valid;
  logic [31:0] o_rd_data;
  logic        i_rd_ready = 1'b0;
  logic        o_icap_csb, o_icap_rdwrb;
  logic [31:0] o_icap_i;
  logic [31:0] i_icap_o = '0;
  logic        i_icap_busy = 1'b0;

  always #5 i_clk = ~i_clk;

  icap_readback_ctrl #(.TIMEOUT_CYCLES(Tmo), .FIFO_DEPTH(Depth)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_frame_addr (i_frame_addr),
    .i_word_count (i_word_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .i_rd_ready   (i_rd_ready),
    .o_icap_csb   (o_icap_csb),
    .o_icap_rdwrb (o_icap_rdwrb),
    .o_icap_i     (o_icap_i),
    .i_icap_o     (i_icap_o),
    .i_icap_busy  (i_icap_busy)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] data_q[$];
  logic [31:0] wr_log[$];
  logic [31:0] out_log[$];
  bit          csb_h[$];
  bit          rdw_h[$];
  int k, pops, done_cnt, max_occ, occ_viol, stuck_busy;
  bit err_seen;

  function automatic logic [31:0] rev(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[(i / 8) * 8 + 7 - (i % 8)] = w[i];
    return r;
  endfunction

  // ready_mode: 0 always ready, 1 not ready before cycle 60, 2 random.
  // busy_mode: 0 low, 1 random, 2 stuck high once 2 words were delivered.
  task automatic run(input logic [31:0] far, input logic [26:0] wc, input int ready_mode,
                     input int busy_mode, input int stop_k, input int extra_start,
                     output bit finished);
    int n, post, hold, occ;
    bit prev_req, prev_rdw, cap;
    n = (wc == 0) ? 1 : int'(wc);
    data_q.delete();
    for (int i = 0; i < n + 2; i++) data_q.push_back($urandom);
    wr_log.delete(); out_log.delete(); csb_h.delete(); rdw_h.delete();
    k = 0; pops = 0; done_cnt = 0; max_occ = 0; occ_viol = 0; stuck_busy = 0; err_seen = 0;
    prev_req = 0; prev_rdw = 0; post = 0; hold = 0; finished = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge i_clk);
      i_start      = (cyc == 0) || (cyc == extra_start);
      i_frame_addr = far;
      i_word_count = wc;
      case (ready_mode)
        0:       i_rd_ready = 1'b1;
        1:       i_rd_ready = (cyc >= 60);
        default: i_rd_ready = 1'($urandom_range(0, 1));
      endcase
      case (busy_mode)
        0: i_icap_busy = 1'b0;
        1: i_icap_busy = 1'($urandom_range(0, 1));
        default: begin
          if (k >= 2 && hold < StuckLen) begin
            i_icap_busy = 1'b1;
            hold++;
          end else begin
            i_icap_busy = 1'b0;
          end
        end
      endcase
      i_icap_o = rev(data_q[k]);
      #1;
      occ = k - pops;
      cap = prev_req && !i_icap_busy;
      if (prev_rdw && o_icap_rdwrb) begin
        if (occ >= int'(Depth) - 1 && !o_icap_csb) occ_viol++;
        if (occ <= int'(Depth) - 2 && o_icap_csb && !(cap && k == n - 1)) occ_viol++;
        if (i_icap_busy && !o_icap_csb) stuck_busy++;
        else stuck_busy = 0;
      end
      if (!o_icap_csb && !o_icap_rdwrb) wr_log.push_back(rev(o_icap_i));
      if (cap) k++;
      if (o_rd_valid && i_rd_ready) begin
        out_log.push_back(o_rd_data);
        pops++;
      end
      if (o_done) done_cnt++;
      if (o_error) err_seen = 1;
      if (k - pops > max_occ) max_occ = k - pops;
      csb_h.push_back(o_icap_csb);
      rdw_h.push_back(o_icap_rdwrb);
      prev_req = !o_icap_csb && o_icap_rdwrb;
      prev_rdw = o_icap_rdwrb;
      if (stop_k >= 0 && k >= stop_k) begin
        finished = 1;
        break;
      end
      if (done_cnt > 0) post++;
      if (done_cnt > 0 && pops >= k && post > 3) begin
        finished = 1;
        break;
      end
    end
    i_start = 1'b0;
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL run_bound: run did not complete within cycle budget (k=%0d)", k);
    end
  endtask

  task automatic expect_writes(input string name, input logic [31:0] far, input int n);
    logic [31:0] exp [16];
    exp = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000, 32'h2000_0000,
            32'h3000_8001, 32'h0000_0004, 32'h3000_2001, far,
            32'h2800_6000, 32'h4800_0000 | 32'(n), 32'h2000_0000, 32'h2000_0000,
            32'h3000_8001, 32'h0000_000D, 32'h2000_0000, 32'h2000_0000};
    total++;
    if (wr_log.size() != 16) begin
      bad++;
      $display("FAIL %s write_count: got %0d want 16", name, wr_log.size());
    end
    for (int i = 0; i < 16 && i < wr_log.size(); i++) begin
      total++;
      if (wr_log[i] !== exp[i]) begin
        bad++;
        $display("FAIL %s write[%0d]: got %08h want %08h", name, i, wr_log[i], exp[i]);
      end
    end
  endtask

  task automatic expect_data(input string name, input int n);
    total++;
    if (out_log.size() != n) begin
      bad++;
      $display("FAIL %s word_count: got %0d want %0d", name, out_log.size(), n);
    end
    for (int i = 0; i < n && i < out_log.size(); i++) begin
      total++;
      if (out_log[i] !== data_q[i]) begin
        bad++;
        $display("FAIL %s word[%0d]: got %08h want %08h", name, i, out_log[i], data_q[i]);
      end
    end
  endtask

  task automatic expect_done(input string name);
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
    end
  endtask

  // At each RDWRB change CSB is high and goes low again on the next cycle.
  task automatic check_turnaround(input string name);
    int changes, viol;
    changes = 0;
    viol = 0;
    for (int t = 1; t + 1 < csb_h.size(); t++) begin
      if (rdw_h[t] != rdw_h[t-1]) begin
        changes++;
        if (!(csb_h[t] == 1'b1 && csb_h[t+1] == 1'b0)) viol++;
      end
    end
    total++;
    if (changes != 2 || viol != 0) begin
      bad++;
      $display("FAIL %s turnaround: changes=%0d bad=%0d want changes=2 bad=0", name, changes, viol);
    end
  endtask

  task automatic test_reset();
    int viol;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      total++;
      if (o_icap_csb !== 1'b1 || o_busy !== 1'b0 || o_rd_valid !== 1'b0 ||
          o_icap_rdwrb !== 1'b0 || o_icap_i !== 32'h0 || o_done !== 1'b0 || o_error !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle c%0d: csb=%b busy=%b valid=%b rdwrb=%b i=%08h done=%b err=%b want 1 0 0 0 0 0 0",
                 c, o_icap_csb, o_busy, o_rd_valid, o_icap_rdwrb, o_icap_i, o_done, o_error);
      end
    end
  endtask

  task automatic test_basic();
    bit fin;
    run(32'h0040_0000, 27'd5, 0, 0, -1, -1, fin);
    expect_writes("basic", 32'h0040_0000, 5);
    expect_data("basic", 5);
    expect_done("basic");
    check_turnaround("basic");
    total++;
    if (err_seen) begin
      bad++;
      $display("FAIL basic error: got 1 want 0");
    end
  endtask

  task automatic test_backpressure();
    bit fin;
    run(32'h0040_0000, 27'd5, 1, 0, -1, -1, fin);
    expect_writes("backpressure", 32'h0040_0000, 5);
    expect_data("backpressure", 5);
    expect_done("backpressure");
    total++;
    if (occ_viol != 0) begin
      bad++;
      $display("FAIL backpressure csb_headroom: violations=%0d want 0", occ_viol);
    end
    total++;
    if (max_occ != int'(Depth)) begin
      bad++;
      $display("FAIL backpressure max_occupancy: got %0d want %0d", max_occ, Depth);
    end
  endtask

  task automatic test_random_busy();
    bit fin;
    logic [31:0] far;
    far = $urandom;
    run(far, 27'd64, 2, 1, -1, 30, fin);  // extra start while busy must be ignored
    expect_writes("random_busy", far, 64);
    expect_data("random_busy", 64);
    expect_done("random_busy");
    check_turnaround("random_busy");
    total++;
    if (occ_viol != 0) begin
      bad++;
      $display("FAIL random_busy csb_headroom: violations=%0d want 0", occ_viol);
    end
  endtask

  task automatic test_zero_count();
    bit fin;
    run(32'h0012_3400, 27'd0, 2, 1, -1, -1, fin);
    expect_writes("zero_count", 32'h0012_3400, 1);
    expect_data("zero_count", 1);
    expect_done("zero_count");
  endtask

  task automatic test_reset_mid();
    bit fin;
    run(32'h0040_0000, 27'd10, 1, 0, 3, -1, fin);
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_icap_csb !== 1'b1 || o_busy !== 1'b0 || o_rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid async: csb=%b busy=%b valid=%b want 1 0 0",
               o_icap_csb, o_busy, o_rd_valid);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    run(32'h00AB_CD00, 27'd2, 0, 0, -1, -1, fin);
    expect_writes("reset_mid", 32'h00AB_CD00, 2);
    expect_data("reset_mid", 2);
    expect_done("reset_mid");
  endtask

  task automatic test_stuck();
    bit fin;
`ifdef RDBK_TIMEOUT_EN
    run(32'h0040_0000, 27'd6, 0, 2, -1, -1, fin);
    expect_writes("timeout", 32'h0040_0000, 6);
    expect_data("timeout", 2);
    expect_done("timeout");
    total++;
    if (o_error !== 1'b1) begin
      bad++;
      $display("FAIL timeout error: got %b want 1", o_error);
    end
    total++;
    if (stuck_busy != int'(Tmo)) begin
      bad++;
      $display("FAIL timeout busy_cycles: got %0d want %0d", stuck_busy, Tmo);
    end
    run(32'h0040_0000, 27'd3, 0, 0, -1, -1, fin);
    expect_data("timeout_clear", 3);
    total++;
    if (o_error !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear error: got %b want 0", o_error);
    end
`else
    run(32'h0040_0000, 27'd4, 0, 2, -1, -1, fin);
    expect_writes("stuck", 32'h0040_0000, 4);
    expect_data("stuck", 4);
    expect_done("stuck");
    total++;
    if (err_seen) begin
      bad++;
      $display("FAIL stuck error: got 1 want 0");
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_busy();
    test_zero_count();
    test_reset_mid();
    test_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icap_readback_ctrl.md
Name: icap_readback_ctrl

Overview:
- Readback counterpart to the bitstream-write ICAP controller: issues the Virtex-6 configuration readback command sequence, switches ICAP to read, and returns frame data words on a valid/ready stream.
- Drives ICAP_VIRTEX6 pins (X32 width) via ports. The primitive is instantiated at the top level, shared through a mux with the write controller.
- Used for configuration verification and scrubbing of partially reconfigured regions.

Parameters:
- TIMEOUT_CYCLES, 4096, consecutive BUSY-high cycles in READ before abort (only with RDBK_TIMEOUT_EN).
- FIFO_DEPTH, 4, output buffer depth in words (power of 2, >=4).

Ports:
- i_clk  in  1  ICAP/control clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_frame_addr  in  32  FAR value for first frame.
- i_word_count  in  27  number of FDRO words to read (includes pad frame); 0 is treated as 1.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse on return to IDLE.
- o_error  out  1  sticky timeout flag; cleared by next accepted i_start.
- o_rd_data  out  32  readback word, byte-bit-order corrected.
- o_rd_valid  out  1  o_rd_data valid.
- i_rd_ready  in  1  consumer accepts word when valid&&ready.
- o_icap_csb  out  1  ICAP CSB, active low.
- o_icap_rdwrb  out  1  ICAP RDWRB (0 = write, 1 = read).
- o_icap_i  out  32  ICAP I bus.
- i_icap_o  in  32  ICAP O bus.
- i_icap_busy  in  1  ICAP BUSY.

Behaviour:
- Reset values: o_icap_csb=1, o_icap_rdwrb=0, o_icap_i=0, o_busy=0, o_done=0, o_error=0, o_rd_valid=0, FIFO empty, state IDLE.
- Bit order: every word on o_icap_i is the logical word with bits reversed within each byte. Each captured i_icap_o word gets the same per-byte reversal before entering the FIFO.
- States: IDLE -> CMD -> TO_RD -> READ -> TO_WR -> DESYNC -> IDLE.
- IDLE: CSB=1. On i_start, latch FAR and count (0->1), clear o_error, go CMD next cycle.
- CMD: CSB=0, RDWRB=0, one word per cycle, index 0..11:
  - FFFFFFFF, AA995566, 20000000, 20000000
  - 30008001, 00000004 (RCFG)
  - 30002001, FAR
  - 28006000, 48000000|count
  - 20000000, 20000000
  - 12 cycles total, then TO_RD.
- TO_RD: CSB=1 for 1 cycle with RDWRB=1. Then READ.
- READ:
  - CSB=0 when FIFO occupancy <= FIFO_DEPTH-2, else CSB=1 (one-word headroom for in-flight capture).
  - Capture i_icap_o when the previous cycle had CSB=0 and current i_icap_busy=0.
  - Remaining counter decrements per capture. When it reaches 0, force CSB=1 immediately and go TO_WR.
- TO_WR: CSB=1, RDWRB=0 for 1 cycle. Then DESYNC.
- DESYNC: CSB=0, RDWRB=0, words 30008001, 0000000D, 20000000, 20000000 (4 cycles). Then IDLE with o_done pulse.
- FIFO output:
  - First-word-fall-through; o_rd_valid = !empty.
  - Simultaneous push and pop at full-1 is allowed.
  - A push when full is impossible by construction; assert in sim.
- Return to IDLE is not gated on the FIFO draining. Words may remain valid after o_done.
- i_start while o_busy=1 is ignored.
- Reset mid-operation: all state cleared asynchronously, FIFO flushed, CSB=1. The ICAP is left unsynchronised; the next run's sync word recovers it.

Optional Feature:
- Macro RDBK_TIMEOUT_EN.
- Defined: counter of consecutive READ cycles with i_icap_busy=1 and CSB low. When it reaches TIMEOUT_CYCLES, set o_error=1 and go TO_WR -> DESYNC -> IDLE with o_done. Partial data already in the FIFO stays valid. The counter resets on each capture.
- Undefined: no counter. READ waits indefinitely; o_error is tied to 0.

Test Plan:
- Reset then idle 20 cycles -> CSB=1, o_busy=0, o_rd_valid=0, no ICAP activity.
- i_start, FAR=00400000, count=5, BUSY model low, ready=1 ->
  - CMD: exact 12 words byte-bit-reversed on o_icap_i; word 9 logical 48000005.
  - Read: 5 words out in order, reversed back to the model's logical values.
  - DESYNC: 4 words, then o_done pulse, o_error=0.
- Same start with i_rd_ready=0 throughout READ -> CSB rises once occupancy=FIFO_DEPTH-1. No word is lost or duplicated after ready=1; total 5 words.
- BUSY toggling randomly, count=64 -> exactly 64 words, no capture in any busy cycle. CSB is high for exactly 1 cycle at each RDWRB change.
- Assert i_rst_n low mid-READ (word 3 of 10), then restart with count=2 -> full command sequence replays, exactly 2 words, FIFO holds no stale data.
- RDBK_TIMEOUT_EN, TIMEOUT_CYCLES=16, BUSY stuck high after 2 words -> o_error=1 after 16 busy cycles, DESYNC issued, o_done pulse, 2 words delivered.
